// File: rtl/reg_file_sb.sv
// Parametrised architectural register file with a link-register write port and a
// per-register busy scoreboard. Optional write-through read bypass: REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int RA_IDX   = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   reg_rs_id,
  input  logic [ADDR_W-1:0]   reg_rt_id,
  output logic [DATA_W-1:0]   reg_rs_value,
  output logic [DATA_W-1:0]   reg_rt_value,
  output logic                reg_rs_busy,
  output logic                reg_rt_busy,
  input  logic                control_reg_write,
  input  logic [ADDR_W-1:0]   control_write_id,
  input  logic [DATA_W-1:0]   reg_write_value,
  input  logic                ra_write,
  input  logic [DATA_W-1:0]   ra_write_value,
  input  logic                reserve_en,
  input  logic [ADDR_W-1:0]   reserve_id,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam logic [ADDR_W-1:0] RA_ID = ADDR_W'(RA_IDX);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic gen_wr;
  logic rsv;

  assign gen_wr = control_reg_write && (control_write_id != '0);
  assign rsv    = reserve_en && (reserve_id != '0);

  // The general port is applied after the ra port so it wins an RA_IDX collision;
  // the reserve is applied last so a newly issued producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (ra_write) begin
      regs_d[RA_ID] = ra_write_value;
      busy_d[RA_ID] = 1'b0;
    end
    if (gen_wr) begin
      regs_d[control_write_id] = reg_write_value;
      busy_d[control_write_id] = 1'b0;
    end
    if (rsv) begin
      busy_d[reserve_id] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Returns {busy, value} as seen by one read port.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] id);
    logic [DATA_W:0] r;
    r = {busy_q[id], regs_q[id]};
`ifdef REGFILE_BYPASS_EN
    if (gen_wr && (control_write_id == id)) begin
      r = {rsv && (reserve_id == id), reg_write_value};
    end else if (ra_write && (id == RA_ID)) begin
      r = {rsv && (reserve_id == id), ra_write_value};
    end
`endif
    return r;
  endfunction

  always_comb begin
    {reg_rs_busy, reg_rs_value} = read_port(reg_rs_id);
    {reg_rt_busy, reg_rt_value} = read_port(reg_rt_id);
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a 16x16 instance for the main scenarios and a
// 32x32 instance (RA_IDX=31) for the wide link-register case.
module tb_reg_file_sb;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 16-register instance
  logic [3:0]  a_rs_id, a_rt_id, a_write_id, a_reserve_id;
  logic [15:0] a_rs_value, a_rt_value, a_write_value, a_ra_value, a_busy_mask;
  logic        a_rs_busy, a_rt_busy, a_control_reg_write, a_ra_write, a_reserve_en;

  // 32-register instance
  logic [4:0]  b_rs_id, b_rt_id, b_write_id, b_reserve_id;
  logic [31:0] b_rs_value, b_rt_value, b_write_value, b_ra_value, b_busy_mask;
  logic        b_rs_busy, b_rt_busy, b_control_reg_write, b_ra_write, b_reserve_en;

  reg_file_sb #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .RA_IDX(9)) dut_a (
    .clock(clock), .reset(reset),
    .reg_rs_id(a_rs_id), .reg_rt_id(a_rt_id),
    .reg_rs_value(a_rs_value), .reg_rt_value(a_rt_value),
    .reg_rs_busy(a_rs_busy), .reg_rt_busy(a_rt_busy),
    .control_reg_write(a_control_reg_write), .control_write_id(a_write_id),
    .reg_write_value(a_write_value),
    .ra_write(a_ra_write), .ra_write_value(a_ra_value),
    .reserve_en(a_reserve_en), .reserve_id(a_reserve_id),
    .busy_mask(a_busy_mask)
  );

  reg_file_sb #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .RA_IDX(31)) dut_b (
    .clock(clock), .reset(reset),
    .reg_rs_id(b_rs_id), .reg_rt_id(b_rt_id),
    .reg_rs_value(b_rs_value), .reg_rt_value(b_rt_value),
    .reg_rs_busy(b_rs_busy), .reg_rt_busy(b_rt_busy),
    .control_reg_write(b_control_reg_write), .control_write_id(b_write_id),
    .reg_write_value(b_write_value),
    .ra_write(b_ra_write), .ra_write_value(b_ra_value),
    .reserve_en(b_reserve_en), .reserve_id(b_reserve_id),
    .busy_mask(b_busy_mask)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  event         sample_ev;
  logic         done     = 1'b0;

  localparam int S_RS = 0, S_RT = 1, S_RS_BUSY = 2, S_RT_BUSY = 3, S_MASK = 4,
                 S_B_RS = 5, S_B_RT = 6;

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      S_RS:      return W'(a_rs_value);
      S_RT:      return W'(a_rt_value);
      S_RS_BUSY: return W'(a_rs_busy);
      S_RT_BUSY: return W'(a_rt_busy);
      S_MASK:    return W'(a_busy_mask);
      S_B_RS:    return b_rs_value;
      S_B_RT:    return b_rt_value;
      default:   return '1;
    endcase
  endfunction

  // Monitor: pops every pending expectation when the driver presents a sample point
  always @(sample_ev) begin
    logic [W-1:0] e, act;
    int           s;
    string        nm;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      s   = sel_q.pop_front();
      nm  = name_q.pop_front();
      act = observe(s);
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, e);
    end
  end

  // Watchdog: the stimulus must complete within a bounded time
  initial begin
    #100000;
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL watchdog: stimulus did not complete before the wait expired");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end else begin
      n_pass++;
    end
  end

  // Driver tasks
  task automatic check(input string nm, input int sel, input logic [W-1:0] e);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(nm);
    -> sample_ev;
    #1;
  endtask

  task automatic idle_inputs();
    a_control_reg_write = 1'b0; a_ra_write = 1'b0; a_reserve_en = 1'b0;
    b_control_reg_write = 1'b0; b_ra_write = 1'b0; b_reserve_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic rd(input logic [3:0] rs, input logic [3:0] rt);
    a_rs_id = rs;
    a_rt_id = rt;
    #1;
  endtask

  task automatic gen_write(input logic [3:0] id, input logic [15:0] v);
    a_control_reg_write = 1'b1; a_write_id = id; a_write_value = v;
  endtask

  task automatic reserve(input logic [3:0] id);
    a_reserve_en = 1'b1; a_reserve_id = id;
  endtask

  initial begin
    idle_inputs();
    a_rs_id = '0; a_rt_id = '0; a_write_id = '0; a_reserve_id = '0;
    a_write_value = '0; a_ra_value = '0;
    b_rs_id = '0; b_rt_id = '0; b_write_id = '0; b_reserve_id = '0;
    b_write_value = '0; b_ra_value = '0;
    reset = 1'b1;
    #12;
    rd(4'd9, 4'd3);
    check("reset_hold_rs", S_RS, 32'h0);
    check("reset_hold_mask", S_MASK, 32'h0);
    n_checks++;
    if ((a_rs_value !== 16'h0) || (a_rt_value !== 16'h0) || (a_rs_busy !== 1'b0) ||
        (a_rt_busy !== 1'b0) || (a_busy_mask !== 16'h0) || (b_busy_mask !== 32'h0)) begin
      $display("FAIL reset_state: rs=0x%0h rt=0x%0h rs_busy=%0b rt_busy=%0b mask=0x%0h b_mask=0x%0h",
               a_rs_value, a_rt_value, a_rs_busy, a_rt_busy, a_busy_mask, b_busy_mask);
    end else begin
      n_pass++;
    end
    reset = 1'b0;
    step();

    // All registers read zero after reset; id 0 ignores writes and reserves
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      check($sformatf("post_reset_rs_%0d", i), S_RS, 32'h0);
    end
    check("post_reset_mask", S_MASK, 32'h0);
    gen_write(4'd0, 16'hBEEF);
    reserve(4'd0);
    step();
    rd(4'd0, 4'd0);
    check("r0_write_ignored", S_RS, 32'h0);
    check("r0_reserve_ignored", S_MASK, 32'h0);

    // Write-to-read latency
    gen_write(4'd3, 16'h1234);
    rd(4'd3, 4'd0);
`ifdef REGFILE_BYPASS_EN
    check("wr3_same_cycle", S_RS, 32'h1234);
`else
    check("wr3_same_cycle", S_RS, 32'h0);
`endif
    check("wr3_same_cycle_busy", S_RS_BUSY, 32'h0);
    step();
    rd(4'd3, 4'd3);
    check("wr3_after_edge_rs", S_RS, 32'h1234);
    check("wr3_after_edge_rt", S_RT, 32'h1234);

    // Both ports target RA_IDX on one edge: general port wins, busy cleared
    reserve(4'd9);
    step();
    rd(4'd9, 4'd9);
    check("ra_reserved_mask", S_MASK, 32'h0200);
    gen_write(4'd9, 16'hAAAA);
    a_ra_write = 1'b1; a_ra_value = 16'h5555;
    rd(4'd9, 4'd9);
`ifdef REGFILE_BYPASS_EN
    check("collision_bypass", S_RS, 32'hAAAA);
`endif
    step();
    check("collision_value", S_RS, 32'hAAAA);
    check("collision_busy_clear", S_MASK, 32'h0);
    reserve(4'd9);
    step();
    a_ra_write = 1'b1; a_ra_value = 16'h5555;
    step();
    rd(4'd9, 4'd9);
    check("ra_only_value", S_RT, 32'h5555);
    check("ra_only_busy_clear", S_RT_BUSY, 32'h0);

    // Reserve / write interplay on id 5
    reserve(4'd5);
    step();
    rd(4'd5, 4'd5);
    check("rsv5_rs_busy", S_RS_BUSY, 32'h1);
    check("rsv5_rt_busy", S_RT_BUSY, 32'h1);
    check("rsv5_mask", S_MASK, 32'h0020);
    gen_write(4'd5, 16'h0042);
    reserve(4'd5);
    step();
    check("wr_rsv5_value", S_RS, 32'h0042);
    check("wr_rsv5_busy", S_RS_BUSY, 32'h1);
    gen_write(4'd5, 16'h0043);
    step();
    check("wr5_value", S_RS, 32'h0043);
    check("wr5_busy_clear", S_RS_BUSY, 32'h0);
    gen_write(4'd6, 16'h6666);
    step();
    rd(4'd6, 4'd5);
    check("wr6_nonbusy_value", S_RS, 32'h6666);
    check("wr6_nonbusy_busy", S_RS_BUSY, 32'h0);

    // Asynchronous reset between edges
    reserve(4'd2);
    step();
    reserve(4'd7);
    step();
    gen_write(4'd4, 16'h4444);
    step();
    rd(4'd4, 4'd3);
    check("pre_reset_r4", S_RS, 32'h4444);
    check("pre_reset_mask", S_MASK, 32'h0084);
    reset = 1'b1;
    #1;
    check("async_reset_r4", S_RS, 32'h0);
    check("async_reset_r3", S_RT, 32'h0);
    check("async_reset_mask", S_MASK, 32'h0);
    gen_write(4'd3, 16'h7777);
    @(posedge clock);
    #3;
    reset = 1'b0;
    idle_inputs();
    rd(4'd4, 4'd3);
    check("write_lost_in_reset", S_RT, 32'h0);
    step();

    // Wide instance: link register at the top index
    b_ra_write = 1'b1; b_ra_value = 32'hDEADBEEF;
    step();
    b_rs_id = 5'd31; b_rt_id = 5'd31;
    #1;
    check("wide_ra_rs", S_B_RS, 32'hDEADBEEF);
    check("wide_ra_rt", S_B_RT, 32'hDEADBEEF);

    #5;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks) $display("PASS");
    else $display("FAIL %0d check(s) failed", n_checks - n_pass);
    $finish;
  end
endmodule
